// File: rtl/quant_conv2d_relu_stream_if.sv
// Result stream between the conv engine and the pooling stage:
// 8-bit result, valid/ready handshake and a last-pixel marker.
interface quant_conv2d_relu_stream_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/quant_conv2d_relu_stream.sv
// quant_conv2d_relu_stream: int8 conv2d + ReLU engine with virtual zero padding,
// stride, signed weights/bias, input zero point and multiplier/shift requant.
// One MAC per cycle; each output pixel goes BIAS -> MAC(TAPS) -> DRAIN -> REQ -> OUT.
// Optional build macro: QCONV_ROUND_EN (round half up before the requant shift;
// without it the shift truncates toward -inf).
module quant_conv2d_relu_stream #(
    parameter int          IN_CH  = 1,
    parameter int          OUT_CH = 32,
    parameter int          K      = 3,
    parameter int          IN_W   = 28,
    parameter int          IN_H   = 28,
    parameter int          PAD    = 1,
    parameter int          STRIDE = 1,
    parameter int unsigned MULT   = 32'd16177215,
    parameter int          SHIFT  = 26,
    parameter int          IN_ZP  = 0,
    parameter int          OUT_ZP = 0,
    localparam int IFM_DEPTH = IN_CH * IN_H * IN_W,
    localparam int WT_DEPTH  = OUT_CH * IN_CH * K * K,
    localparam int IFM_AW    = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1,
    localparam int WT_AW     = (WT_DEPTH > 1) ? $clog2(WT_DEPTH) : 1,
    localparam int B_AW      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              ifm_we,
    input  logic [IFM_AW-1:0] ifm_addr,
    input  logic [7:0]        ifm_wdata,
    input  logic              wt_we,
    input  logic [WT_AW-1:0]  wt_addr,
    input  logic [7:0]        wt_wdata,
    input  logic              b_we,
    input  logic [B_AW-1:0]   b_addr,
    input  logic [31:0]       b_wdata,
    quant_conv2d_relu_stream_if.master out_if
);

    localparam int OUT_W = (IN_W + 2 * PAD - K) / STRIDE + 1;
    localparam int OUT_H = (IN_H + 2 * PAD - K) / STRIDE + 1;
    localparam int TAPS  = IN_CH * K * K;

    localparam logic [8:0]         IN_ZP_S  = 9'(IN_ZP);
    localparam logic signed [63:0] MULT_S   = 64'(MULT);
    localparam logic signed [63:0] OUT_ZP_S = 64'(OUT_ZP);
`ifdef QCONV_ROUND_EN
    localparam logic signed [63:0] RND_S    = 64'sd1 <<< (SHIFT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_REQ   = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    logic [7:0]  ifm_mem_r [IFM_DEPTH];
    logic [7:0]  wt_mem_r  [WT_DEPTH];
    logic [31:0] b_mem_r   [OUT_CH];

    state_t             state_r;
    logic [31:0]        oc_r, oy_r, ox_r;
    logic [31:0]        ky_r, kx_r, ic_r;
    logic signed [31:0] acc_r;
    logic [7:0]         x_r, w_r;
    logic               tap_vld_r;

    logic signed [31:0] iy_s, ix_s;
    logic               tap_in_s;
    logic [IFM_AW-1:0]  ifm_idx_s;
    logic [WT_AW-1:0]   wt_idx_s;
    logic               last_tap_s, last_pix_s;
    logic signed [8:0]  x_op_s;
    logic signed [16:0] prod_s;
    logic signed [31:0] acc_nx_s;
    logic signed [63:0] p_s, pr_s, r_s, y_s;
    logic [7:0]         q_s;

    // Load path: the RAMs are filled between layers; writes are dropped while a layer runs.
    always_ff @(posedge clk) begin
        if (!busy) begin
            if (ifm_we) ifm_mem_r[ifm_addr] <= ifm_wdata;
            if (wt_we)  wt_mem_r[wt_addr]   <= wt_wdata;
            if (b_we)   b_mem_r[b_addr]     <= b_wdata;
        end
    end

    // Tap addressing: map (oy,ox,ky,kx,ic) to padded input coordinates and RAM indices.
    always_comb begin
        iy_s       = $signed(oy_r * 32'(STRIDE) + ky_r - 32'(PAD));
        ix_s       = $signed(ox_r * 32'(STRIDE) + kx_r - 32'(PAD));
        tap_in_s   = (iy_s >= 32'sd0) && (iy_s < 32'(IN_H)) &&
                     (ix_s >= 32'sd0) && (ix_s < 32'(IN_W));
        ifm_idx_s  = IFM_AW'((ic_r * 32'(IN_H) + $unsigned(iy_s)) * 32'(IN_W) + $unsigned(ix_s));
        wt_idx_s   = WT_AW'(oc_r * 32'(TAPS) + ic_r * 32'(K * K) + ky_r * 32'(K) + kx_r);
        last_tap_s = (ky_r == 32'(K - 1)) && (kx_r == 32'(K - 1)) && (ic_r == 32'(IN_CH - 1));
        last_pix_s = (ox_r == 32'(OUT_W - 1)) && (oy_r == 32'(OUT_H - 1)) &&
                     (oc_r == 32'(OUT_CH - 1));
    end

    // Datapath: 9b zero-point-corrected operand times int8 weight, accumulate with 32b wrap.
    always_comb begin
        x_op_s = $signed({1'b0, x_r}) - $signed(IN_ZP_S);
        prod_s = x_op_s * $signed(w_r);
        if (tap_vld_r) begin
            acc_nx_s = acc_r + 32'(prod_s);
        end else begin
            acc_nx_s = acc_r;
        end
    end

    // Requant: 64b product, optional rounding, arithmetic shift, zero point, clamp (ReLU).
    always_comb begin
        p_s = 64'(acc_r) * MULT_S;
`ifdef QCONV_ROUND_EN
        pr_s = p_s + RND_S;
`else
        pr_s = p_s;
`endif
        r_s = pr_s >>> SHIFT;
        y_s = r_s + OUT_ZP_S;
        if (y_s < OUT_ZP_S) begin
            q_s = 8'(OUT_ZP);
        end else if (y_s > 64'sd255) begin
            q_s = 8'd255;
        end else begin
            q_s = y_s[7:0];
        end
    end

    // Control FSM: pixel scan (oc, oy, ox), tap issue, output handshake and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r          <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= 8'd0;
            out_if.out_last  <= 1'b0;
            oc_r             <= 32'd0;
            oy_r             <= 32'd0;
            ox_r             <= 32'd0;
            ky_r             <= 32'd0;
            kx_r             <= 32'd0;
            ic_r             <= 32'd0;
            acc_r            <= 32'sd0;
            x_r              <= 8'd0;
            w_r              <= 8'd0;
            tap_vld_r        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        oc_r    <= 32'd0;
                        oy_r    <= 32'd0;
                        ox_r    <= 32'd0;
                        state_r <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    acc_r     <= $signed(b_mem_r[B_AW'(oc_r)]);
                    tap_vld_r <= 1'b0;
                    ky_r      <= 32'd0;
                    kx_r      <= 32'd0;
                    ic_r      <= 32'd0;
                    state_r   <= S_MAC;
                end
                S_MAC: begin
                    acc_r <= acc_nx_s;
                    if (tap_in_s) begin
                        x_r       <= ifm_mem_r[ifm_idx_s];
                        w_r       <= wt_mem_r[wt_idx_s];
                        tap_vld_r <= 1'b1;
                    end else begin
                        tap_vld_r <= 1'b0;
                    end
                    if (ic_r == 32'(IN_CH - 1)) begin
                        ic_r <= 32'd0;
                        if (kx_r == 32'(K - 1)) begin
                            kx_r <= 32'd0;
                            ky_r <= ky_r + 32'd1;
                        end else begin
                            kx_r <= kx_r + 32'd1;
                        end
                    end else begin
                        ic_r <= ic_r + 32'd1;
                    end
                    if (last_tap_s) begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    acc_r     <= acc_nx_s;
                    tap_vld_r <= 1'b0;
                    state_r   <= S_REQ;
                end
                S_REQ: begin
                    out_if.out_data  <= q_s;
                    out_if.out_last  <= last_pix_s;
                    out_if.out_valid <= 1'b1;
                    state_r          <= S_OUT;
                end
                S_OUT: begin
                    if (out_if.out_valid && out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        out_if.out_last  <= 1'b0;
                        if (last_pix_s) begin
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            if (ox_r == 32'(OUT_W - 1)) begin
                                ox_r <= 32'd0;
                                if (oy_r == 32'(OUT_H - 1)) begin
                                    oy_r <= 32'd0;
                                    oc_r <= oc_r + 32'd1;
                                end else begin
                                    oy_r <= oy_r + 32'd1;
                                end
                            end else begin
                                ox_r <= ox_r + 32'd1;
                            end
                            state_r <= S_BIAS;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quant_conv2d_relu_stream.sv
// Bench for quant_conv2d_relu_stream. Two instances:
//   A: 4x4 map, PAD=1, STRIDE=1, 2 channels, identity requant (MULT=16, SHIFT=4)
//   B: 5x5 map, PAD=0, STRIDE=2, 1 channel, MULT=1, SHIFT=1 (exposes rounding)
// Expected pixels go into a scoreboard queue; a negedge monitor pops and compares.
module tb_quant_conv2d_relu_stream;

    localparam int LAT = 9 + 4;  // negedges from accept/start to next out_valid (TAPS=9)
`ifdef QCONV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       dut;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;

    logic        clk;
    logic        rstn;
    logic        a_start, b_start;
    logic        a_busy, a_done, b_busy, b_done;
    logic        ld_sel, ifm_we, wt_we, b_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    quant_conv2d_relu_stream_if a_if();
    quant_conv2d_relu_stream_if b_if();

    initial clk = 1'b0;
    always #5 clk = ~clk;

    quant_conv2d_relu_stream #(
        .IN_CH(1), .OUT_CH(2), .K(3), .IN_W(4), .IN_H(4), .PAD(1), .STRIDE(1),
        .MULT(32'd16), .SHIFT(4), .IN_ZP(0), .OUT_ZP(0)
    ) u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .busy(a_busy), .done(a_done),
        .ifm_we(ifm_we & ~ld_sel), .ifm_addr(ld_addr[3:0]), .ifm_wdata(ld_data[7:0]),
        .wt_we(wt_we & ~ld_sel), .wt_addr(ld_addr[4:0]), .wt_wdata(ld_data[7:0]),
        .b_we(b_we & ~ld_sel), .b_addr(ld_addr[0:0]), .b_wdata(ld_data),
        .out_if(a_if.master)
    );

    quant_conv2d_relu_stream #(
        .IN_CH(1), .OUT_CH(1), .K(3), .IN_W(5), .IN_H(5), .PAD(0), .STRIDE(2),
        .MULT(32'd1), .SHIFT(1), .IN_ZP(0), .OUT_ZP(0)
    ) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .busy(b_busy), .done(b_done),
        .ifm_we(ifm_we & ld_sel), .ifm_addr(ld_addr[4:0]), .ifm_wdata(ld_data[7:0]),
        .wt_we(wt_we & ld_sel), .wt_addr(ld_addr[3:0]), .wt_wdata(ld_data[7:0]),
        .b_we(b_we & ld_sel), .b_addr(ld_addr[0:0]), .b_wdata(ld_data),
        .out_if(b_if.master)
    );

    logic [7:0] m_data[2];
    logic       m_valid[2], m_ready[2], m_last[2], m_done[2], m_busy[2], m_start[2];
    assign m_data[0]  = a_if.out_data;   assign m_data[1]  = b_if.out_data;
    assign m_valid[0] = a_if.out_valid;  assign m_valid[1] = b_if.out_valid;
    assign m_ready[0] = a_if.out_ready;  assign m_ready[1] = b_if.out_ready;
    assign m_last[0]  = a_if.out_last;   assign m_last[1]  = b_if.out_last;
    assign m_done[0]  = a_done;          assign m_done[1]  = b_done;
    assign m_busy[0]  = a_busy;          assign m_busy[1]  = b_busy;
    assign m_start[0] = a_start;         assign m_start[1] = b_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor state per instance
    int         gap[2];
    bit         armed[2];
    bit         held[2];
    logic [8:0] held_v[2];
    int         dchk[2];
    bit         drop[2];

    // Monitor: scoreboard compare on handshake, plus hold, latency and done-pulse checks
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            for (int g = 0; g < 2; g++) begin
                armed[g] = 1'b0; held[g] = 1'b0; dchk[g] = 0; drop[g] = 1'b0; gap[g] = 0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (dchk[g] == 1) begin
                    check("done_pulse", 32'(m_done[g]), 32'd1);
                    dchk[g] = 2;
                end else if (dchk[g] == 2) begin
                    check("done_width", 32'(m_done[g]), 32'd0);
                    dchk[g] = 0;
                end else if (m_done[g] !== 1'b0) begin
                    check("done_spurious", 32'(m_done[g]), 32'd0);
                end
                if (drop[g]) begin
                    check("valid_drop", 32'(m_valid[g]), 32'd0);
                    drop[g] = 1'b0;
                end
                if (armed[g]) begin
                    gap[g]++;
                    if (m_valid[g]) begin
                        check("pixel_latency", 32'(gap[g]), 32'(LAT));
                        armed[g] = 1'b0;
                    end
                end
                if (m_valid[g] === 1'b1) begin
                    if (m_ready[g]) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_out: dut%0d got %0d, expected no output", g, m_data[g]);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_dut", 32'(g), 32'(e.dut));
                            check("out_data", 32'(m_data[g]), 32'(e.data));
                            check("out_last", 32'(m_last[g]), 32'(e.last));
                        end
                        held[g] = 1'b0;
                        drop[g] = 1'b1;
                        if (m_last[g]) begin
                            dchk[g] = 1;
                        end else begin
                            armed[g] = 1'b1;
                            gap[g]   = 0;
                        end
                    end else begin
                        if (held[g]) check("hold_stable", 32'({m_last[g], m_data[g]}), 32'(held_v[g]));
                        held[g]   = 1'b1;
                        held_v[g] = {m_last[g], m_data[g]};
                    end
                end else begin
                    held[g] = 1'b0;
                end
                if (m_start[g] && !m_busy[g]) begin
                    armed[g] = 1'b1;
                    gap[g]   = 0;
                end
            end
        end
    end

    // kind: 0 = feature map, 1 = weights, 2 = bias
    task automatic wr(input logic sel, input int kind, input int addr, input logic [31:0] d);
        ld_sel  = sel;
        ld_addr = 8'(addr);
        ld_data = d;
        ifm_we  = (kind == 0);
        wt_we   = (kind == 1);
        b_we    = (kind == 2);
        @(posedge clk); #1;
        ifm_we = 1'b0; wt_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic start_layer(input logic sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
        check("busy_set", 32'(sel ? b_busy : a_busy), 32'd1);
    endtask

    task automatic wait_idle(input logic sel, input int budget);
        int n;
        n = 0;
        while ((sel ? b_busy : a_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("layer_timeout", 32'(sel ? b_busy : a_busy), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Instance A: channel 0 has w=+1, channel 1 w=-1; x constant; count = in-range taps
    task automatic push_a(input int bias0, input int bias1, input int x);
        exp_t e;
        int   cnt, acc;
        for (int oc = 0; oc < 2; oc++)
            for (int oy = 0; oy < 4; oy++)
                for (int ox = 0; ox < 4; ox++) begin
                    cnt    = ((oy == 0 || oy == 3) ? 2 : 3) * ((ox == 0 || ox == 3) ? 2 : 3);
                    acc    = (oc == 0) ? bias0 + x * cnt : bias1 - x * cnt;
                    e.data = (acc < 0) ? 8'd0 : (acc > 255) ? 8'd255 : 8'(acc);
                    e.last = (oc == 1 && oy == 3 && ox == 3);
                    e.dut  = 1'b0;
                    exp_q.push_back(e);
                end
    endtask

    task automatic push_b(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        exp_t e;
        logic [7:0] v[4];
        v[0] = d0; v[1] = d1; v[2] = d2; v[3] = d3;
        for (int i = 0; i < 4; i++) begin
            e.data = v[i];
            e.last = (i == 3);
            e.dut  = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rstn = 1'b1; a_start = 1'b0; b_start = 1'b0;
        ld_sel = 1'b0; ifm_we = 1'b0; wt_we = 1'b0; b_we = 1'b0;
        ld_addr = 8'd0; ld_data = 32'd0;
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_busy",  32'(a_busy), 32'd0);
        check("rst_a_done",  32'(a_done), 32'd0);
        check("rst_a_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_a_data",  32'(a_if.out_data), 32'd0);
        check("rst_a_last",  32'(a_if.out_last), 32'd0);
        check("rst_b_busy",  32'(b_busy), 32'd0);
        check("rst_b_valid", 32'(b_if.out_valid), 32'd0);
        check("rst_b_data",  32'(b_if.out_data), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // A layer 1: x=1, corner 4 / edge 6 / centre 9, channel 1 all ReLU'd to 0
        for (int i = 0; i < 16; i++) wr(1'b0, 0, i, 32'd1);
        for (int i = 0; i < 9; i++) begin
            wr(1'b0, 1, i, 32'h01);
            wr(1'b0, 1, 9 + i, 32'hFF);
        end
        wr(1'b0, 2, 0, 32'd0);
        wr(1'b0, 2, 1, 32'd0);
        push_a(0, 0, 1);
        start_layer(1'b0);
        wait_idle(1'b0, 3000);

        // A layer 2: x=10, bias0=200 (corner 240, others clamp 255), channel 1 -> 0
        for (int i = 0; i < 16; i++) wr(1'b0, 0, i, 32'd10);
        wr(1'b0, 2, 0, 32'd200);
        push_a(200, 0, 10);
        start_layer(1'b0);
        repeat (60) @(posedge clk);
        #1;
        wr(1'b0, 2, 1, 32'd5000);          // dropped: layer is running
        a_start = 1'b1;                    // ignored: layer is running
        @(posedge clk); #1;
        a_start = 1'b0;
        a_if.out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        a_if.out_ready = 1'b1;
        wait_idle(1'b0, 3000);

        // B layer 1: x[i]=i, centre weight only, bias 1 -> acc 7,9,17,19 then >>1
        for (int i = 0; i < 25; i++) wr(1'b1, 0, i, 32'(i));
        for (int i = 0; i < 9; i++) wr(1'b1, 1, i, (i == 4) ? 32'd1 : 32'd0);
        wr(1'b1, 2, 0, 32'd1);
        if (RND) push_b(8'd4, 8'd5, 8'd9, 8'd10);
        else     push_b(8'd3, 8'd4, 8'd8, 8'd9);
        start_layer(1'b1);
        wait_idle(1'b1, 1000);

        // B abort: reset in the middle of the first pixel's MAC phase
        start_layer(1'b1);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort_busy",  32'(b_busy), 32'd0);
        check("abort_done",  32'(b_done), 32'd0);
        check("abort_valid", 32'(b_if.out_valid), 32'd0);
        check("abort_data",  32'(b_if.out_data), 32'd0);
        check("abort_last",  32'(b_if.out_last), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // B rerun from the retained RAM contents: same four results
        if (RND) push_b(8'd4, 8'd5, 8'd9, 8'd10);
        else     push_b(8'd3, 8'd4, 8'd8, 8'd9);
        start_layer(1'b1);
        wait_idle(1'b1, 1000);

        // B layer 2: weights zero, bias 3 -> acc=3 -> 2 rounded, 1 truncated
        wr(1'b1, 1, 4, 32'd0);
        wr(1'b1, 2, 0, 32'd3);
        if (RND) push_b(8'd2, 8'd2, 8'd2, 8'd2);
        else     push_b(8'd1, 8'd1, 8'd1, 8'd1);
        start_layer(1'b1);
        wait_idle(1'b1, 1000);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
